fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the PC register, drives the instruction-memory address, and owns the F/D pipeline latch that feeds decode.
- Honours stall requests from data-hazard control and redirects from execute for taken branches and jumps.
- Keeps saturating fetch, flush and stall counters for bench probing.

Parameters:
- IMEM_AW, 12, instruction-memory address width in words.
- RESET_PC, 32'd0, PC value after reset.
- NOP_INSN, 32'd0, instruction injected into F/D on a flush.

Ports:
- clock  in  1  single pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  from hazard control; hold PC and F/D.
- redirect_valid  in  1  from execute; taken branch/jump this cycle.
- redirect_target  in  32  new PC (word address) when redirect_valid=1.
- address_imem  out  IMEM_AW  = pc_out[IMEM_AW-1:0].
- q_imem  in  32  instruction at address_imem; valid in the same cycle (imem clocked on the opposite edge at top level).
- pc_out  out  32  current PC register.
- pc_in  out  32  next-PC mux output (combinational).
- fd_insn_out  out  32  F/D latched instruction.
- fd_pc_out  out  32  PC of fd_insn_out.
- fd_pc_plus1_out  out  32  fd_pc_out+1, used for branch/jal target and $r31.
- fd_valid_out  out  1  F/D holds a real instruction, not a bubble.
- fetch_count  out  32  valid instructions delivered into F/D.
- flush_count  out  32  redirects taken.
- stall_count  out  32  cycles with stall=1 and redirect_valid=0.

Behaviour:
- PC is word-addressed; sequential increment is +1, mod 2^32. 32'hFFFFFFFF wraps to 0.
- Next-PC priority, highest first:
  - reset: RESET_PC.
  - redirect_valid: redirect_target.
  - stall: pc_out.
  - otherwise: pc_out+1.
  - pc_in shows this selection combinationally; the PC register loads pc_in every edge.
- F/D latch, same priority:
  - reset: insn=NOP_INSN, pc=0, pc_plus1=0, valid=0.
  - redirect_valid: insn=NOP_INSN, valid=0, pc/pc_plus1 unchanged. Squashes the wrong-path instruction; redirect beats a simultaneous stall because the branch is older.
  - stall: all F/D fields hold.
  - otherwise: insn=q_imem, pc=pc_out, pc_plus1=pc_out+1, valid=1.
- Latency:
  - Instruction at PC p appears on fd_insn_out one edge after pc_out=p, unless stalled or flushed that cycle.
  - After a redirect at edge k: pc_out=target at k; the target instruction reaches F/D at k+1.
- address_imem truncates the PC to IMEM_AW bits. Upper PC bits are ignored for addressing, so a PC of 4096 fetches word 0 when IMEM_AW=12. No exception is raised.
- redirect_target is used as-is, with no alignment or range check.
- Counters (reset to 0; each saturates at 32'hFFFFFFFF and holds):
  - fetch_count increments on edges where F/D loads with valid=1.
  - flush_count increments on edges with redirect_valid=1, including when stall=1.
  - stall_count increments on edges with stall=1 and redirect_valid=0.
- Reset asserted mid-stream, including mid-stall or during a redirect, overrides everything on that edge. After reset, all outputs are at their reset values; fetch resumes at RESET_PC on the first edge with reset=0.
- Reset output values:
  - pc_out=RESET_PC.
  - fd_insn_out=NOP_INSN, fd_pc_out=0, fd_pc_plus1_out=0, fd_valid_out=0.
  - All counters 0.
  - address_imem=RESET_PC[IMEM_AW-1:0].
- No internal state machine beyond the PC, F/D and counter registers. The stage is either running, holding (stall) or squashing (redirect), decided per cycle by the priority above.

Test Plan:
- Straight-line: reset 2 cycles, imem[i]=i+100, no stall/redirect for 5 cycles.
  - Required: pc_out=0,1,2,3,4,5.
  - fd_insn_out=100..104 with fd_pc_out=0..4 and fd_valid_out=1.
  - fetch_count=5.
- Stall: assert stall 3 cycles while pc_out=3.
  - Required: pc_out stays 3 and fd_insn_out stays 102 for 3 edges; stall_count=3.
  - After release: fd_insn_out=103, pc_out=4.
- Redirect: redirect_valid=1, target=40 while pc_out=6.
  - Next edge: pc_out=40, fd_insn_out=0, fd_valid_out=0, flush_count=1.
  - Following edge: fd_insn_out=140, fd_pc_out=40, fd_pc_plus1_out=41.
- Redirect with simultaneous stall: target=10.
  - Required: pc_out=10, F/D squashed to a bubble, flush_count increments, stall_count unchanged.
- Wrap/truncation:
  - Redirect to 32'hFFFFFFFF: next pc_out=0, address_imem=0.
  - Redirect to 4097: address_imem=1.
- Reset mid-stall: stall=1 at pc_out=7, then reset for 1 edge.
  - Required: pc_out=0, fd_valid_out=0, all counters 0.
  - After release with stall=0: fd_insn_out=100.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and the F/D latch.
// Redirect beats stall because the branch in execute is older than the stalled fetch.
module fetch_stage #(
    parameter int          IMEM_AW  = 12,
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP_INSN = 32'd0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [IMEM_AW-1:0] address_imem,
    input  logic [31:0]        q_imem,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_in,
    output logic [31:0]        fd_insn_out,
    output logic [31:0]        fd_pc_out,
    output logic [31:0]        fd_pc_plus1_out,
    output logic               fd_valid_out,
    output logic [31:0]        fetch_count,
    output logic [31:0]        flush_count,
    output logic [31:0]        stall_count
);

    logic [31:0] pc_q;
    logic [31:0] fdInsn_q, fdInsn_d;
    logic [31:0] fdPc_q, fdPc_d;
    logic [31:0] fdPcPlus1_q, fdPcPlus1_d;
    logic        fdValid_q, fdValid_d;
    logic [31:0] fetchCount_q, fetchCount_d;
    logic [31:0] flushCount_q, flushCount_d;
    logic [31:0] stallCount_q, stallCount_d;
    logic [31:0] pcPlus1;
    logic        advance;

    assign pcPlus1 = pc_q + 32'd1;
    assign advance = !reset && !redirect_valid && !stall;

    always_comb begin
        if (reset) begin
            pc_in = RESET_PC;
        end else if (redirect_valid) begin
            pc_in = redirect_target;
        end else if (stall) begin
            pc_in = pc_q;
        end else begin
            pc_in = pcPlus1;
        end
    end

    always_comb begin
        fdInsn_d    = fdInsn_q;
        fdPc_d      = fdPc_q;
        fdPcPlus1_d = fdPcPlus1_q;
        fdValid_d   = fdValid_q;
        if (redirect_valid) begin
            fdInsn_d  = NOP_INSN;
            fdValid_d = 1'b0;
        end else if (!stall) begin
            fdInsn_d    = q_imem;
            fdPc_d      = pc_q;
            fdPcPlus1_d = pcPlus1;
            fdValid_d   = 1'b1;
        end
    end

    // Probe counters stick at all-ones rather than wrapping back to zero.
    always_comb begin
        fetchCount_d = fetchCount_q;
        flushCount_d = flushCount_q;
        stallCount_d = stallCount_q;
        if (advance && fetchCount_q != 32'hFFFF_FFFF) begin
            fetchCount_d = fetchCount_q + 32'd1;
        end
        if (redirect_valid && flushCount_q != 32'hFFFF_FFFF) begin
            flushCount_d = flushCount_q + 32'd1;
        end
        if (stall && !redirect_valid && stallCount_q != 32'hFFFF_FFFF) begin
            stallCount_d = stallCount_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        pc_q <= pc_in;
        if (reset) begin
            fdInsn_q     <= NOP_INSN;
            fdPc_q       <= 32'd0;
            fdPcPlus1_q  <= 32'd0;
            fdValid_q    <= 1'b0;
            fetchCount_q <= 32'd0;
            flushCount_q <= 32'd0;
            stallCount_q <= 32'd0;
        end else begin
            fdInsn_q     <= fdInsn_d;
            fdPc_q       <= fdPc_d;
            fdPcPlus1_q  <= fdPcPlus1_d;
            fdValid_q    <= fdValid_d;
            fetchCount_q <= fetchCount_d;
            flushCount_q <= flushCount_d;
            stallCount_q <= stallCount_d;
        end
    end

    assign address_imem    = pc_q[IMEM_AW-1:0];
    assign pc_out          = pc_q;
    assign fd_insn_out     = fdInsn_q;
    assign fd_pc_out       = fdPc_q;
    assign fd_pc_plus1_out = fdPcPlus1_q;
    assign fd_valid_out    = fdValid_q;
    assign fetch_count     = fetchCount_q;
    assign flush_count     = flushCount_q;
    assign stall_count     = stallCount_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    localparam int IMEM_AW = 12;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               stall = 1'b0;
    logic               redirectValid = 1'b0;
    logic [31:0]        redirectTarget = 32'd0;
    logic [IMEM_AW-1:0] addressImem;
    logic [31:0]        qImem;
    logic [31:0]        pcOut, pcIn, fdInsn, fdPc, fdPcPlus1;
    logic               fdValid;
    logic [31:0]        fetchCount, flushCount, stallCount;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] mPc = 32'd0, mFdInsn = 32'd0, mFdPc = 32'd0, mFdPc1 = 32'd0;
    logic        mFdValid = 1'b0;
    logic [31:0] mFetch = 32'd0, mFlush = 32'd0, mStall = 32'd0;

    fetch_stage #(.IMEM_AW(IMEM_AW), .RESET_PC(32'd0), .NOP_INSN(32'd0)) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirectValid),
        .redirect_target(redirectTarget),
        .address_imem(addressImem),
        .q_imem(qImem),
        .pc_out(pcOut),
        .pc_in(pcIn),
        .fd_insn_out(fdInsn),
        .fd_pc_out(fdPc),
        .fd_pc_plus1_out(fdPcPlus1),
        .fd_valid_out(fdValid),
        .fetch_count(fetchCount),
        .flush_count(flushCount),
        .stall_count(stallCount)
    );

    always #5 clock = ~clock;

    // Instruction memory contents: word i holds i+100.
    assign qImem = 32'(addressImem) + 32'd100;

    function automatic logic [31:0] imemWord(input logic [31:0] pc);
        return (pc % 32'd4096) + 32'd100;
    endfunction

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelNextPc(input logic r, input logic st, input logic rv,
                                                input logic [31:0] tgt);
        if (r) return 32'd0;
        if (rv) return tgt;
        if (st) return mPc;
        return mPc + 32'd1;
    endfunction

    task automatic checkAll();
        checkOutput("pc_out", pcOut, mPc);
        checkOutput("address_imem", 32'(addressImem), mPc % 32'd4096);
        checkOutput("fd_insn", fdInsn, mFdInsn);
        checkOutput("fd_pc", fdPc, mFdPc);
        checkOutput("fd_pc_plus1", fdPcPlus1, mFdPc1);
        checkOutput("fd_valid", 32'(fdValid), 32'(mFdValid));
        checkOutput("fetch_count", fetchCount, mFetch);
        checkOutput("flush_count", flushCount, mFlush);
        checkOutput("stall_count", stallCount, mStall);
    endtask

    // Drive one cycle of inputs, check the combinational next PC, clock, then check state.
    task automatic applyStimulus(input logic r, input logic st, input logic rv, input logic [31:0] tgt);
        logic [31:0] nextPc;
        reset = r;
        stall = st;
        redirectValid = rv;
        redirectTarget = tgt;
        #1;
        nextPc = modelNextPc(r, st, rv, tgt);
        checkOutput("pc_in", pcIn, nextPc);
        @(posedge clock);
        if (r) begin
            mFdInsn = 32'd0; mFdPc = 32'd0; mFdPc1 = 32'd0; mFdValid = 1'b0;
            mFetch = 32'd0; mFlush = 32'd0; mStall = 32'd0;
        end else if (rv) begin
            mFdInsn = 32'd0; mFdValid = 1'b0;
            mFlush = satInc(mFlush);
        end else if (st) begin
            mStall = satInc(mStall);
        end else begin
            mFdInsn = imemWord(mPc); mFdPc = mPc; mFdPc1 = mPc + 32'd1; mFdValid = 1'b1;
            mFetch = satInc(mFetch);
        end
        mPc = nextPc;
        #1;
        checkAll();
    endtask

    initial begin
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("straight_pc", pcOut, 32'd5);
        checkOutput("straight_insn", fdInsn, 32'd104);
        checkOutput("straight_fetch", fetchCount, 32'd5);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b1, 32'd40);
        checkOutput("redir_pc", pcOut, 32'd40);
        checkOutput("redir_bubble", 32'(fdValid), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("redir_target_insn", fdInsn, 32'd140);
        checkOutput("redir_target_pc1", fdPcPlus1, 32'd41);

        applyStimulus(1'b0, 1'b1, 1'b1, 32'd10);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("wrap_pc", pcOut, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'd4097);
        checkOutput("trunc_addr", 32'(addressImem), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("post_reset_insn", fdInsn, 32'd100);

        for (int i = 0; i < 400; i++) begin
            logic r, st, rv;
            logic [31:0] tgt;
            r  = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8191));
            applyStimulus(r, st, rv, tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
